// File: rtl/key_event_pkg.sv
// key_event_pkg: shared types and constants for the key event capture block
package key_event_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_e;
  localparam int CODE_W = 3;
  localparam logic [CODE_W:0] IDLE_SYNC_VALUE = 4'b1111;
endpackage

// File: rtl/key_fifo.sv
// key_fifo: synchronous FIFO with registered storage, no fall-through
module key_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic do_push, do_pop;
  assign full  = level_q == LVL_W'(DEPTH);
  assign empty = level_q == '0;
  assign level = level_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = wdata;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    level_d  = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

// File: rtl/key_event_capture.sv
// key_event_capture: debounces a 74HC148-style encoder and queues one key code per confirmed press
module key_event_capture
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int LVL_W           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CODE_W-1:0] enc_code_n,
  input  logic              enc_gs_n,
  output logic              enc_ei_n,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow,
  input  logic              ovf_clr
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [CODE_W:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CODE_W-1:0] cand_q, cand_d, code_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e state_q, state_d;
  logic gs_s, push, pop, full, empty, ovf_q, ovf_d, ei_n_q, ei_n_d;
  assign gs_s      = sync2_q[CODE_W];
  assign code_s    = sync2_q[CODE_W-1:0];
  assign key_valid = !empty;
  assign pop       = key_valid && key_ready;
  assign overflow  = ovf_q;
  assign enc_ei_n  = ei_n_q;
  always_comb begin
    sync1_d = {enc_gs_n, enc_code_n};
    sync2_d = sync1_q;
    ei_n_d  = !en;
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    push    = 1'b0;
    case (state_q)
      IDLE: if (!gs_s) begin
        state_d = PRESS_DB;
        cnt_d   = '0;
        cand_d  = code_s;
      end
      PRESS_DB:
        if (gs_s || code_s != cand_q) state_d = IDLE;
        else if (cnt_q == CNT_MAX) begin
          push    = 1'b1;
          state_d = HELD;
        end else cnt_d = cnt_q + CNT_W'(1);
      HELD: if (gs_s) begin
        state_d = RELEASE_DB;
        cnt_d   = '0;
      end
      RELEASE_DB:
        if (!gs_s) state_d = HELD;
        else if (cnt_q == CNT_MAX) state_d = IDLE;
        else cnt_d = cnt_q + CNT_W'(1);
      default: state_d = IDLE;
    endcase
    if (!en) begin
      state_d = IDLE;
      push    = 1'b0;
    end
    // a dropped press wins over a same-cycle clear so it is never lost silently
    ovf_d = (push && full && !pop) || (ovf_q && !ovf_clr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= IDLE_SYNC_VALUE;
      sync2_q <= IDLE_SYNC_VALUE;
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      ovf_q   <= 1'b0;
      ei_n_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      ovf_q   <= ovf_d;
      ei_n_q  <= ei_n_d;
    end
  end
  key_fifo #(.WIDTH(CODE_W), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata(~cand_q),
    .pop  (pop),
    .rdata(key_code),
    .full (full),
    .empty(empty),
    .level(fifo_level)
  );
endmodule

// File: tb/tb_key_event_capture.sv
// tb_key_event_capture: directed, table-driven self-checking bench for key_event_capture
module tb_key_event_capture;
  logic clk, rst, en, enc_gs_n, enc_ei_n, key_valid, key_ready, overflow, ovf_clr;
  logic [2:0] enc_code_n, key_code;
  logic [2:0] fifo_level;
  int checks = 0;
  int failures = 0;

  key_event_capture #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .enc_code_n(enc_code_n), .enc_gs_n(enc_gs_n),
    .enc_ei_n(enc_ei_n), .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .fifo_level(fifo_level), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] code_n;
    int         hold;
    bit         ev;
    logic [2:0] code;
  } vec_t;
  vec_t vecs[6];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic release_pins();
    enc_gs_n   = 1;
    enc_code_n = 3'b111;
  endtask

  task automatic press_confirm(input logic [2:0] code);
    enc_gs_n   = 0;
    enc_code_n = ~code;
    step(8);
    release_pins();
    step(10);
  endtask

  initial begin
    vecs[0] = '{3'b010, 12, 1'b1, 3'd5};
    vecs[1] = '{3'b000, 8, 1'b1, 3'd7};
    vecs[2] = '{3'b111, 8, 1'b1, 3'd0};
    vecs[3] = '{3'b101, 5, 1'b1, 3'd2};
    vecs[4] = '{3'b011, 4, 1'b0, 3'd0};
    vecs[5] = '{3'b110, 2, 1'b0, 3'd0};

    rst = 1; en = 0; key_ready = 0; ovf_clr = 0;
    release_pins();
    step(2);
    rst = 0;
    step(1);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ei_n", enc_ei_n, 1);
    en = 1;
    step(1);
    chk("en_ei_n", enc_ei_n, 0);

    // single presses: key_valid must rise exactly 7 edges after the first sample
    key_ready = 1;
    for (int v = 0; v < 6; v++) begin
      enc_gs_n   = 0;
      enc_code_n = vecs[v].code_n;
      for (int i = 1; i <= 12; i++) begin
        step(1);
        if (i == vecs[v].hold) release_pins();
        if (i <= 8) chk($sformatf("v%0d_valid_c%0d", v, i), key_valid, (vecs[v].ev && i == 7) ? 1 : 0);
        if (i == 7 && vecs[v].ev) chk($sformatf("v%0d_code", v), key_code, vecs[v].code);
      end
      release_pins();
      step(10);
      chk($sformatf("v%0d_level_end", v), fifo_level, 0);
    end

    // bounce rejection
    repeat (3) begin
      enc_gs_n = 0; enc_code_n = 3'b010;
      step(2);
      release_pins();
      step(2);
    end
    step(10);
    chk("bounce_gs_level", fifo_level, 0);
    enc_gs_n = 0;
    for (int i = 0; i < 8; i++) begin
      enc_code_n = i[0] ? 3'b011 : 3'b010;
      step(2);
    end
    release_pins();
    step(10);
    chk("bounce_code_level", fifo_level, 0);

    // release glitch must not create a second entry
    key_ready = 0;
    enc_gs_n = 0; enc_code_n = 3'b001;
    step(8);
    chk("glitch_first", fifo_level, 1);
    enc_gs_n = 1;
    step(2);
    enc_gs_n = 0;
    step(8);
    chk("glitch_no_second", fifo_level, 1);
    release_pins();
    step(10);
    enc_gs_n = 0; enc_code_n = 3'b100;
    step(8);
    release_pins();
    chk("glitch_second_press", fifo_level, 2);
    chk("glitch_head0", key_code, 6);
    key_ready = 1;
    step(1);
    chk("glitch_head1", key_code, 3);
    step(1);
    key_ready = 0;
    chk("glitch_drained", fifo_level, 0);
    step(10);

    // overflow: fifth press dropped
    for (int k = 1; k <= 5; k++) press_confirm(3'(k));
    chk("ovf_level", fifo_level, 4);
    chk("ovf_set", overflow, 1);
    key_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovf_pop%0d", k), key_code, k);
      step(1);
    end
    key_ready = 0;
    chk("ovf_empty", key_valid, 0);
    chk("ovf_sticky", overflow, 1);
    ovf_clr = 1;
    step(1);
    ovf_clr = 0;
    chk("ovf_cleared", overflow, 0);

    // push into a full FIFO accepted when a pop happens in the same cycle
    press_confirm(3'd6); press_confirm(3'd7); press_confirm(3'd0); press_confirm(3'd1);
    chk("full_level", fifo_level, 4);
    enc_gs_n = 0; enc_code_n = ~3'd2;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (i == 6) key_ready = 1;
      if (i == 7) begin
        key_ready = 0;
        chk("fullpop_level", fifo_level, 4);
        chk("fullpop_ovf", overflow, 0);
      end
    end
    release_pins();
    step(10);
    key_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fullpop_order%0d", k), key_code, (k == 3) ? 2 : (7 + k) % 8);
      step(1);
    end
    key_ready = 0;
    chk("fullpop_drained", fifo_level, 0);

    // disable on the very cycle the push would happen
    press_confirm(3'd4); press_confirm(3'd5);
    enc_gs_n = 0; enc_code_n = ~3'd6;
    step(6);
    en = 0;
    step(1);
    chk("dis_ei_n", enc_ei_n, 1);
    chk("dis_no_push", fifo_level, 2);
    step(3);
    release_pins();
    step(10);
    en = 1;
    step(1);
    chk("dis_reen_ei_n", enc_ei_n, 0);
    chk("dis_level", fifo_level, 2);
    key_ready = 1;
    chk("dis_pop0", key_code, 4);
    step(1);
    chk("dis_pop1", key_code, 5);
    step(1);
    key_ready = 0;
    chk("dis_empty", key_valid, 0);

    // reset while held: key is recaptured as a new press
    enc_gs_n = 0; enc_code_n = 3'b000;
    step(8);
    chk("held_level", fifo_level, 1);
    rst = 1;
    step(1);
    chk("hrst_valid", key_valid, 0);
    chk("hrst_code", key_code, 0);
    chk("hrst_level", fifo_level, 0);
    chk("hrst_ovf", overflow, 0);
    chk("hrst_ei_n", enc_ei_n, 1);
    rst = 0;
    step(6);
    chk("recap_early", key_valid, 0);
    step(1);
    chk("recap_valid", key_valid, 1);
    chk("recap_code", key_code, 7);
    release_pins();
    step(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/key_event_capture.md
Name: key_event_capture

Overview:
- Sits directly downstream of the 8-to-3 active-low priority encoder (74HC148-style).
- Synchronises and debounces the encoder's GS/code outputs and converts each confirmed key press into one true-binary key code.
- Buffers key codes in a small FIFO and presents them on a valid/ready interface.
- Drives the encoder's active-low EI so the encoder can be enabled or disabled from logic.

Parameters:
- DEBOUNCE_CYCLES, 16, synced-level stability window in clk cycles (≥2; bench uses 4).
- FIFO_DEPTH, 4, key FIFO entries (power of 2, ≥2).
- LVL_W, $clog2(FIFO_DEPTH)+1, width of fifo_level.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  capture enable
- enc_code_n  in  3  encoder DataOut, active-low code, asynchronous to clk
- enc_gs_n  in  1  encoder GS, low = some input active
- enc_ei_n  out  1  encoder EI drive, active-low
- key_code  out  3  FIFO head, true binary (7 = highest priority input)
- key_valid  out  1  FIFO non-empty
- key_ready  in  1  consumer accepts head
- fifo_level  out  LVL_W  entries held
- overflow  out  1  sticky: a confirmed press was dropped
- ovf_clr  in  1  clears overflow

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - FSM = IDLE, counter 0.
  - Sync flops all 1 (idle encoder).
  - FIFO empty: key_valid 0, key_code 0, fifo_level 0.
  - overflow 0.
  - enc_ei_n 1.
- enc_ei_n: registered ~en.
- Synchroniser: 2-flop on {enc_gs_n, enc_code_n}. The outputs gs_s and code_s are the only values the FSM sees.
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB; one counter `cnt`.
  - IDLE: gs_s==0 → PRESS_DB, cnt=0, latch cand=code_s.
  - PRESS_DB:
    - gs_s==1 or code_s!=cand → IDLE.
    - else if cnt==DEBOUNCE_CYCLES-1 → push ~cand, go to HELD.
    - else cnt++.
  - HELD: gs_s==1 → RELEASE_DB, cnt=0. Code changes while held (higher key added) are ignored; there is no new event until a full release.
  - RELEASE_DB:
    - gs_s==0 → HELD.
    - else if cnt==DEBOUNCE_CYCLES-1 → IDLE.
    - else cnt++.
- en==0: FSM is forced to IDLE next edge and no push occurs, including one pending in that same cycle. FIFO contents and the pop interface keep operating.
- Latency: pins stable-pressed before edge e1 → key_valid=1 after edge e1+DEBOUNCE_CYCLES+2, i.e. DEBOUNCE_CYCLES+3 edges counting e1.
- FIFO rules:
  - Registered head; no fall-through. A push into an empty FIFO is visible on the next cycle.
  - Pop when key_valid && key_ready.
  - Push when full with no pop: entry dropped, overflow←1.
  - Push when full with a pop in the same cycle: accepted, level unchanged, no overflow.
  - Push and pop on an empty FIFO: pop ignored, level becomes 1.
  - Pointers wrap modulo FIFO_DEPTH; fifo_level saturates at FIFO_DEPTH.
- overflow: set dominates ovf_clr when both occur in the same cycle. Cleared only by ovf_clr or rst.
- Reset mid-debounce or mid-hold: everything returns to reset values. A key still held after reset is captured again as a new press via IDLE.

Decomposition:
- Package key_event_pkg:
  - state enum {IDLE, PRESS_DB, HELD, RELEASE_DB}
  - constant CODE_W=3
  - IDLE_SYNC_VALUE = 4'b1111
- Sub-module key_fifo: generic synchronous FIFO, parameters WIDTH, DEPTH, with push/pop/full/empty/level.
- Synchroniser and FSM stay in the top module.

Test Plan:
- Reset check: assert rst 2 cycles with encoder pins idle (gs_n=1, code_n=3'b111) → after release, key_valid=0, key_code=0, fifo_level=0, overflow=0, enc_ei_n=1; en=1 → enc_ei_n=0 next edge.
- Single press, DEBOUNCE_CYCLES=4, key_ready=1 held: drive code_n=3'b010, gs_n=0 for 12 cycles → key_valid=1 with key_code=5 exactly 7 edges after first sample, for one cycle only, then level returns to 0.
- Bounce rejection: gs_n=0 for 2 cycles then 1, repeated 3× → no event, fifo_level stays 0. Also hold gs_n=0 while code_n toggles every 2 cycles → no event.
- Release glitch: confirmed press code 6, gs_n high for 2 cycles then low again → no second entry. Full release ≥7 cycles, then press code_n=3'b100 → second entry key_code=3.
- Overflow, key_ready=0: 5 confirmed presses with codes 1,2,3,4,5 → fifo_level=4, overflow=1, popped order 1,2,3,4, code 5 absent. Pulse ovf_clr → overflow=0. Then press while full with key_ready=1 that cycle → accepted, overflow stays 0.
- Disable mid-operation: en=0 during PRESS_DB with FIFO holding 2 entries → enc_ei_n=1 next edge, no push, both entries still pop in order. Also pulse rst during HELD → all outputs return to reset values.
